// File: rtl/lsu_stage_if.sv
// Pipeline and data-memory signals of the load/store stage.
// slave: the stage itself. master: the environment (upstream, downstream and memory).
interface lsu_stage_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  // Upstream instruction handshake
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           instr_i;
  logic [31:0]           alu_result_i;
  logic [31:0]           store_data_i;
  // Downstream result register
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [31:0]           instr_o;
  logic [31:0]           alu_result_o;
  logic [31:0]           data_o;
  logic                  fault_o;
  // Data memory port
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  in_valid_i, instr_i, alu_result_i, store_data_i, out_ready_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output in_ready_o, out_valid_o, instr_o, alu_result_o, data_o, fault_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output in_valid_i, instr_i, alu_result_i, store_data_i, out_ready_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  in_ready_o, out_valid_o, instr_o, alu_result_o, data_o, fault_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_stage.sv
// RV32I load/store stage: decodes memory ops, checks alignment/range, runs one
// request/grant/rvalid memory transaction at a time and presents a registered result.
module lsu_stage #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input logic        clk,
  input logic        rst_n,
  lsu_stage_if.slave bus
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  // Memory op latched at accept, held stable through REQ/WAIT
  logic [31:0] op_instr_q, op_instr_d;
  logic [31:0] op_addr_q, op_addr_d;
  logic [31:0] op_sdata_q, op_sdata_d;
  // Output register
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_alu_q, out_alu_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_fault_q, out_fault_d;

  logic        in_is_load, in_is_store, in_is_mem;
  logic        in_f3_ok, in_misaligned, in_out_of_range, in_fault;
  logic        accept;
  logic        op_is_store;
  logic [2:0]  op_funct3;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;

  assign in_is_load  = (bus.instr_i[6:0] == OpLoad);
  assign in_is_store = (bus.instr_i[6:0] == OpStore);
  assign in_is_mem   = in_is_load | in_is_store;
  assign op_is_store = (op_instr_q[6:0] == OpStore);
  assign op_funct3   = op_instr_q[14:12];

  assign bus.in_ready_o = (state_q == StIdle) && (!out_valid_q || bus.out_ready_i);
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  // Legality of the incoming memory op: funct3, natural alignment and address range
  always_comb begin
    in_f3_ok        = 1'b0;
    in_misaligned   = 1'b0;
    in_out_of_range = |(bus.alu_result_i >> ADDR_WIDTH);
    unique case (bus.instr_i[14:12])
      3'b000: in_f3_ok = 1'b1;
      3'b001: begin
        in_f3_ok      = 1'b1;
        in_misaligned = bus.alu_result_i[0];
      end
      3'b010: begin
        in_f3_ok      = 1'b1;
        in_misaligned = |bus.alu_result_i[1:0];
      end
      3'b100: in_f3_ok = in_is_load;
      3'b101: begin
        in_f3_ok      = in_is_load;
        in_misaligned = bus.alu_result_i[0];
      end
      default: in_f3_ok = 1'b0;
    endcase
    in_fault = in_is_mem && (!in_f3_ok || in_misaligned || in_out_of_range);
  end

  // Load data: align the addressed lane to bit 0, then sign/zero extend
  always_comb begin
    rdata_shifted = bus.mem_rdata_i >> {op_addr_q[1:0], 3'b000};
    unique case (op_funct3)
      3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_data = {24'b0, rdata_shifted[7:0]};
      3'b101:  load_data = {16'b0, rdata_shifted[15:0]};
      default: load_data = bus.mem_rdata_i;
    endcase
  end

  // Next-state: FSM, op latch and output register
  always_comb begin
    state_d     = state_q;
    op_instr_d  = op_instr_q;
    op_addr_d   = op_addr_q;
    op_sdata_d  = op_sdata_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_alu_d   = out_alu_q;
    out_data_d  = out_data_q;
    out_fault_d = out_fault_q;

    if (out_valid_q && bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_is_mem && !in_fault) begin
            op_instr_d = bus.instr_i;
            op_addr_d  = bus.alu_result_i;
            op_sdata_d = bus.store_data_i;
            state_d    = StReq;
          end else begin
            // Pass-through or faulting op completes without touching memory
            out_valid_d = 1'b1;
            out_instr_d = bus.instr_i;
            out_alu_d   = bus.alu_result_i;
            out_data_d  = 32'b0;
            out_fault_d = in_fault;
          end
        end
      end
      StReq: begin
        if (bus.mem_gnt_i) begin
          if (op_is_store) begin
            out_valid_d = 1'b1;
            out_instr_d = op_instr_q;
            out_alu_d   = op_addr_q;
            out_data_d  = 32'b0;
            out_fault_d = 1'b0;
            state_d     = StIdle;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bus.mem_rvalid_i) begin
          out_valid_d = 1'b1;
          out_instr_d = op_instr_q;
          out_alu_d   = op_addr_q;
          out_data_d  = load_data;
          out_fault_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory port: driven only while a request is outstanding
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_be_o    = 4'b0;
    bus.mem_wdata_o = 32'b0;
    if (state_q == StReq) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_addr_o = {op_addr_q[ADDR_WIDTH-1:2], 2'b00};
      bus.mem_be_o   = 4'hF;
      if (op_is_store) begin
        bus.mem_we_o = 1'b1;
        unique case (op_funct3)
          3'b000: begin
            bus.mem_be_o    = 4'b0001 << op_addr_q[1:0];
            bus.mem_wdata_o = {4{op_sdata_q[7:0]}};
          end
          3'b001: begin
            bus.mem_be_o    = 4'b0011 << {op_addr_q[1], 1'b0};
            bus.mem_wdata_o = {2{op_sdata_q[15:0]}};
          end
          default: begin
            bus.mem_be_o    = 4'hF;
            bus.mem_wdata_o = op_sdata_q;
          end
        endcase
      end
    end
  end

  // State registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_instr_q  <= 32'b0;
      op_addr_q   <= 32'b0;
      op_sdata_q  <= 32'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'b0;
      out_alu_q   <= 32'b0;
      out_data_q  <= 32'b0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_instr_q  <= op_instr_d;
      op_addr_q   <= op_addr_d;
      op_sdata_q  <= op_sdata_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_alu_q   <= out_alu_d;
      out_data_q  <= out_data_d;
      out_fault_q <= out_fault_d;
    end
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.instr_o      = out_instr_q;
  assign bus.alu_result_o = out_alu_q;
  assign bus.data_o       = out_data_q;
  assign bus.fault_o      = out_fault_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: expected results are queued when an instruction is
// driven and compared when the stage presents its output register.
module tb_lsu_stage;

  localparam int unsigned AW = 12;

  localparam logic [31:0] IAddi = 32'h00A0_0093;
  localparam logic [31:0] ILb   = 32'h0000_0083;
  localparam logic [31:0] ILh   = 32'h0000_1083;
  localparam logic [31:0] ILw   = 32'h0000_2083;
  localparam logic [31:0] ILd3  = 32'h0000_3083;
  localparam logic [31:0] ILbu  = 32'h0000_4083;
  localparam logic [31:0] ILhu  = 32'h0000_5083;
  localparam logic [31:0] ISb   = 32'h0020_0023;
  localparam logic [31:0] ISh   = 32'h0020_1023;
  localparam logic [31:0] ISw   = 32'h0020_2023;
  localparam logic [31:0] IS4   = 32'h0020_4023;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_stage_if #(.ADDR_WIDTH(AW)) bus ();
  lsu_stage #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [31:0] instr, input logic [31:0] alu,
                               input logic [31:0] data, input logic fault);
    exp_t e;
    e.instr = instr;
    e.alu   = alu;
    e.data  = data;
    e.fault = fault;
    sb_q.push_back(e);
  endfunction

  // Present one instruction; returns half a cycle after the accepting edge
  task automatic send(input logic [31:0] instr, input logic [31:0] alu,
                      input logic [31:0] sdata);
    int n = 0;
    bus.in_valid_i   = 1'b1;
    bus.instr_i      = instr;
    bus.alu_result_i = alu;
    bus.store_data_i = sdata;
    while (bus.in_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("send.in_ready", bus.in_ready_o, 1'b1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  // Wait up to max_wait cycles for a result and compare it with the oldest expectation
  task automatic pop_check(input string tag, input int max_wait);
    int   n = 0;
    exp_t e;
    while (bus.out_valid_o !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, ".out_valid"}, bus.out_valid_o, 1'b1);
    chk({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, ".instr_o"}, bus.instr_o, e.instr);
      chk({tag, ".alu_result_o"}, bus.alu_result_o, e.alu);
      chk({tag, ".data_o"}, bus.data_o, e.data);
      chk1({tag, ".fault_o"}, bus.fault_o, e.fault);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp_data);
    push(instr, addr, exp_data, 1'b0);
    send(instr, addr, 32'h0);
    chk1({tag, ".req"}, bus.mem_req_o, 1'b1);
    chk1({tag, ".we"}, bus.mem_we_o, 1'b0);
    chk({tag, ".be"}, 32'(bus.mem_be_o), 32'hF);
    chk({tag, ".addr"}, 32'(bus.mem_addr_o), addr & 32'hFFC);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    chk1({tag, ".wait_req"}, bus.mem_req_o, 1'b0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = word;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    pop_check(tag, 0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_be, input logic [31:0] exp_wdata);
    push(instr, addr, 32'h0, 1'b0);
    send(instr, addr, sdata);
    chk1({tag, ".lat1_valid"}, bus.out_valid_o, 1'b0);
    chk1({tag, ".req"}, bus.mem_req_o, 1'b1);
    chk1({tag, ".we"}, bus.mem_we_o, 1'b1);
    chk({tag, ".addr"}, 32'(bus.mem_addr_o), exp_addr);
    chk({tag, ".be"}, 32'(bus.mem_be_o), exp_be);
    chk({tag, ".wdata"}, bus.mem_wdata_o, exp_wdata);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    chk1({tag, ".idle_req"}, bus.mem_req_o, 1'b0);
    pop_check(tag, 0);
  endtask

  task automatic fault_case(input string tag, input logic [31:0] instr,
                            input logic [31:0] addr);
    push(instr, addr, 32'h0, 1'b1);
    send(instr, addr, 32'hCAFE_F00D);
    chk1({tag, ".no_req"}, bus.mem_req_o, 1'b0);
    pop_check(tag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.in_valid_i   = 1'b0;
    bus.instr_i      = 32'h0;
    bus.alu_result_i = 32'h0;
    bus.store_data_i = 32'h0;
    bus.out_ready_i  = 1'b1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst.out_valid", bus.out_valid_o, 1'b0);
    chk1("rst.mem_req", bus.mem_req_o, 1'b0);
    chk1("rst.in_ready", bus.in_ready_o, 1'b1);
    chk("rst.instr_o", bus.instr_o, 32'h0);
    chk("rst.data_o", bus.data_o, 32'h0);
    chk1("rst.fault_o", bus.fault_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pass-through, 1-cycle latency, then back-to-back consume-and-accept
    push(IAddi, 32'h0000_0055, 32'h0, 1'b0);
    send(IAddi, 32'h0000_0055, 32'h0);
    chk1("pt.no_req", bus.mem_req_o, 1'b0);
    pop_check("pt_a", 0);
    push(IAddi, 32'hFFFF_1234, 32'h0, 1'b0);
    send(IAddi, 32'hFFFF_1234, 32'h0);
    pop_check("pt_b", 0);

    // Stores
    do_store("sw", ISw, 32'h10, 32'hDEAD_BEEF, 32'h010, 32'hF, 32'hDEAD_BEEF);
    do_store("sh", ISh, 32'h6, 32'h1234_ABCD, 32'h004, 32'hC, 32'hABCD_ABCD);
    do_store("sb3", ISb, 32'h3, 32'h0000_0077, 32'h000, 32'h8, 32'h7777_7777);
    do_store("sb1", ISb, 32'h9, 32'hFFFF_FF5A, 32'h008, 32'h2, 32'h5A5A_5A5A);

    // Loads against memory word 0x80FF7F01
    do_load("lb2", ILb, 32'h2, 32'h80FF_7F01, 32'hFFFF_FFFF);
    do_load("lbu2", ILbu, 32'h2, 32'h80FF_7F01, 32'h0000_00FF);
    do_load("lh2", ILh, 32'h2, 32'h80FF_7F01, 32'hFFFF_80FF);
    do_load("lhu0", ILhu, 32'h0, 32'h80FF_7F01, 32'h0000_7F01);
    do_load("lb1", ILb, 32'h1, 32'h80FF_7F01, 32'h0000_007F);
    do_load("lhu2", ILhu, 32'h2, 32'h80FF_7F01, 32'h0000_80FF);
    do_load("lw4", ILw, 32'h4, 32'h80FF_7F01, 32'h80FF_7F01);
    do_load("lwtop", ILw, 32'hFFC, 32'h0BAD_F00D, 32'h0BAD_F00D);

    // Faulting memory ops
    fault_case("lw_mis3", ILw, 32'h3);
    fault_case("lh_mis1", ILh, 32'h1);
    fault_case("lw_oor", ILw, 32'h1000);
    fault_case("ld_f3", ILd3, 32'h0);
    fault_case("st_f4", IS4, 32'h0);
    fault_case("sw_mis2", ISw, 32'h2);

    // Delayed grant, delayed rvalid, stalled consumer
    push(ILw, 32'h8, 32'h1122_3344, 1'b0);
    send(ILw, 32'h8, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk1("slow.req", bus.mem_req_o, 1'b1);
      chk("slow.addr", 32'(bus.mem_addr_o), 32'h008);
      chk1("slow.in_ready_req", bus.in_ready_o, 1'b0);
      @(negedge clk);
    end
    chk1("slow.req_at_gnt", bus.mem_req_o, 1'b1);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk1("slow.wait_req", bus.mem_req_o, 1'b0);
      chk1("slow.in_ready_wait", bus.in_ready_o, 1'b0);
      @(negedge clk);
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h1122_3344;
    bus.out_ready_i  = 1'b0;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk1("slow.held_valid", bus.out_valid_o, 1'b1);
      chk("slow.held_data", bus.data_o, 32'h1122_3344);
      chk1("slow.in_ready_held", bus.in_ready_o, 1'b0);
      @(negedge clk);
    end
    bus.out_ready_i = 1'b1;
    pop_check("slow", 0);
    @(negedge clk);
    chk1("slow.consumed", bus.out_valid_o, 1'b0);

    // Stray rvalid outside WAIT is ignored
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_5555;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    chk1("stray_idle.out_valid", bus.out_valid_o, 1'b0);

    // Reset while waiting for read data abandons the load
    send(ILb, 32'h2, 32'h0);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    chk1("rstwait.in_wait_req", bus.mem_req_o, 1'b0);
    chk1("rstwait.in_wait_ready", bus.in_ready_o, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rstwait.async_valid", bus.out_valid_o, 1'b0);
    chk1("rstwait.async_req", bus.mem_req_o, 1'b0);
    chk("rstwait.async_instr", bus.instr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h80FF_7F01;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    chk1("rstwait.out_valid", bus.out_valid_o, 1'b0);
    chk1("rstwait.idle", bus.in_ready_o, 1'b1);
    @(negedge clk);
    chk1("rstwait.out_valid2", bus.out_valid_o, 1'b0);
    chk("sb.drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
